mips32_ifetch_queue: RTL and testbench

//  Instruction prefetch stage directly upstream of the IF/ID register of the MIPS32 pipeline.
//  - Fetches 32-bit words from word-addressed instruction memory over a req/ack handshake.
//  - Buffers fetched words in a small FIFO and presents {IR, NPC} to decode over valid/ready.
//  - Branch redirects flush the queue. Fetching stops after an HLT (opcode 6'b111111) is queued.

---
 rtl/mips32_ifetch_queue_if.sv | 30 +++
 rtl/mips32_ifetch_queue.sv | 190 +++++++++++++++++++
 tb/tb_mips32_ifetch_queue.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_ifetch_queue_if.sv
// Bus bundle for the MIPS32 instruction prefetch queue: instruction-memory
// req/ack side, branch redirect inputs and the decode-facing valid/ready side.
interface mips32_ifetch_queue_if #(
  parameter int ADDR_W = 10
);
  // imem: imem_req/imem_addr are held until imem_ack; imem_ack is meaningful only
  // while imem_req=1. Decode: a word moves on a clock edge where out_valid and
  // out_ready are both 1; out_valid never waits on out_ready.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ir;
  logic [31:0]       out_npc;
  logic              halted;

  modport master (
    output imem_req, imem_addr, out_valid, out_ir, out_npc, halted,
    input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_ir, out_npc, halted,
    output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/mips32_ifetch_queue.sv
// MIPS32 instruction prefetch queue feeding IF/ID: single-outstanding fetch FSM plus FIFO.
// Define IFQ_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module mips32_ifetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  mips32_ifetch_queue_if.master bus,
  output logic [1:0]            o_dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HALT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state, w_state_next;
  logic              r_req, w_req_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
  logic              r_drop, w_drop_next;

  logic [31:0]       r_mem_ir  [DEPTH];
  logic [ADDR_W-1:0] r_mem_npc [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_next;

  logic              w_ack;
  logic              w_fill;
  logic              w_enq;
  logic              w_deq;
  logic              w_byp;
  logic              w_q_empty;
  logic              w_is_hlt;
  logic [ADDR_W-1:0] w_addr_inc;

  // An ack only counts against a live request; during drain it is swallowed.
  assign w_ack      = bus.imem_ack & r_req;
  assign w_fill     = w_ack & ~r_drop & ~bus.redirect;
  assign w_q_empty  = (r_count == '0);
  assign w_is_hlt   = (bus.imem_rdata[31:26] == 6'b111111);
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_deq      = ~w_q_empty & bus.out_ready & ~bus.redirect;

`ifdef IFQ_BYPASS_EN
  assign w_byp = w_fill & w_q_empty;
  assign w_enq = w_fill & ~(w_byp & bus.out_ready);
`else
  assign w_byp = 1'b0;
  assign w_enq = w_fill;
`endif

  always_comb begin
    w_count_next = r_count;
    if (bus.redirect) begin
      w_count_next = '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_req_next      = r_req;
    w_addr_next     = r_addr;
    w_fetch_pc_next = r_fetch_pc;
    w_drop_next     = r_drop;
    if (bus.redirect) begin
      w_fetch_pc_next = bus.redirect_pc;
      if (r_state == S_DRAIN) begin
        if (w_ack) begin
          w_state_next = S_IDLE;
          w_req_next   = 1'b0;
          w_drop_next  = 1'b0;
        end
      end else if (r_req && !w_ack) begin
        // The in-flight word belongs to the old path; keep the request up and discard it.
        w_state_next = S_DRAIN;
        w_drop_next  = 1'b1;
      end else begin
        w_state_next = S_IDLE;
        w_req_next   = 1'b0;
        w_drop_next  = 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count < CNT_W'(DEPTH)) begin
            w_state_next = S_REQ;
            w_req_next   = 1'b1;
            w_addr_next  = r_fetch_pc;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            w_fetch_pc_next = w_addr_inc;
            if (w_is_hlt) begin
              w_state_next = S_HALT;
              w_req_next   = 1'b0;
            end else if (w_count_next < CNT_W'(DEPTH)) begin
              w_state_next = S_REQ;
              w_req_next   = 1'b1;
              w_addr_next  = w_addr_inc;
            end else begin
              w_state_next = S_IDLE;
              w_req_next   = 1'b0;
            end
          end
        end
        S_HALT: begin
          w_req_next = 1'b0;
        end
        S_DRAIN: begin
          if (w_ack) begin
            w_state_next = S_IDLE;
            w_req_next   = 1'b0;
            w_drop_next  = 1'b0;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_req_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_drop     <= w_drop_next;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_ir[i]  <= '0;
        r_mem_npc[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      if (bus.redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_enq) begin
          r_mem_ir[r_wr_ptr]  <= bus.imem_rdata;
          r_mem_npc[r_wr_ptr] <= w_addr_inc;
          r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.halted    = (r_state == S_HALT);
  assign bus.out_valid = ~w_q_empty | w_byp;
  assign bus.out_ir    = w_byp ? bus.imem_rdata : r_mem_ir[r_rd_ptr];
  assign bus.out_npc   = 32'(w_byp ? w_addr_inc : r_mem_npc[r_rd_ptr]);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mips32_ifetch_queue.sv
// Self-checking bench for mips32_ifetch_queue: directed steps then randomized traffic,
// outputs compared against an expected instruction stream derived from a memory image.
module tb_mips32_ifetch_queue;

  localparam logic [9:0] RST_PC = 10'd0;
`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk1;
  logic       rst_n;
  logic [1:0] dbg_state;

  mips32_ifetch_queue_if #(.ADDR_W(10)) bus ();

  mips32_ifetch_queue #(
    .DEPTH(4), .ADDR_W(10), .RESET_PC(RST_PC)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  logic [31:0] mem [1024];
  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_ack = 0;
  int n_xfer = 0;
  logic [31:0] last_npc = '0;
  int fixed_lat = 1;
  int slow_addr = -1;
  int slow_lat = 3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    w[31] = 1'b0;
    return w;
  endfunction

  // Expected program-order stream from pc: sequential words up to and including an HLT.
  task automatic sb_refill(input logic [9:0] pc);
    logic [9:0] a;
    logic [9:0] an;
    exp_q.delete();
    a = pc;
    for (int i = 0; i < 256; i++) begin
      an = a + 10'd1;
      exp_q.push_back({22'd0, an, mem[a]});
      if (mem[a][31:26] == 6'b111111) break;
      a = an;
    end
  endtask

  // Instruction memory responder with per-request latency.
  initial begin
    int  wait_cnt;
    bit  pending;
    wait_cnt = 0;
    pending = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk1);
      #1;
      bus.imem_ack = 1'b0;
      if (!rst_n || !bus.imem_req) begin
        pending = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1'b1;
          if (int'(bus.imem_addr) == slow_addr) wait_cnt = slow_lat;
          else if (fixed_lat >= 0) wait_cnt = fixed_lat;
          else wait_cnt = $urandom_range(0, 3);
        end
        if (wait_cnt == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          pending = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Scoreboard / protocol monitor, sampled mid-cycle.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [9:0]  prev_addr;
    logic [63:0] exp;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk1);
      if (!rst_n) begin
        sb_refill(RST_PC);
        prev_req = 1'b0;
      end else begin
        if (bus.imem_req && bus.imem_ack) n_ack++;
        if (prev_req && !prev_ack && bus.imem_req) check("addr_stable", 64'(bus.imem_addr), 64'(prev_addr));
        if (bus.halted) check("halt_no_req", 64'(bus.imem_req), 64'd0);
        if (bus.redirect) begin
          sb_refill(bus.redirect_pc);
        end else if (bus.out_valid && bus.out_ready) begin
          n_xfer++;
          last_npc = bus.out_npc;
          n_cmp++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL out_unexpected: observed npc=%0h ir=%0h expected no transfer", bus.out_npc, bus.out_ir);
          end
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("out_word", {bus.out_npc, bus.out_ir}, exp);
          end
        end
        prev_req = bus.imem_req;
        prev_ack = bus.imem_ack;
        prev_addr = bus.imem_addr;
      end
    end
  end

  initial begin
    int found;
    int cnt;
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();

    // Reset values, then reset asserted mid-request.
    steps(3);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'(RST_PC));
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ir", 64'(bus.out_ir), 64'd0);
    check("rst_npc", 64'(bus.out_npc), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    fixed_lat = 2;
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      step();
      if (bus.out_valid && bus.imem_req) found = 1;
    end
    check("t1_busy_timeout", 64'(found), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t1_req", 64'(bus.imem_req), 64'd0);
    check("t1_valid", 64'(bus.out_valid), 64'd0);
    check("t1_halted", 64'(bus.halted), 64'd0);
    check("t1_addr", 64'(bus.imem_addr), 64'd0);
    steps(2);
    check("t1_req_held", 64'(bus.imem_req), 64'd0);

    // Streaming A0..A3 then HLT, decode always ready.
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
    mem[4] = 32'hFC00_0000;
    fixed_lat = 1;
    bus.out_ready = 1'b1;
    n_xfer = 0;
    step();
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (bus.halted) found = 1;
    end
    check("t2_halt_timeout", 64'(found), 64'd1);
    steps(3);
    check("t2_xfers", 64'(n_xfer), 64'd5);
    check("t2_last_npc", 64'(last_npc), 64'd5);
    check("t2_req_off", 64'(bus.imem_req), 64'd0);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: exactly DEPTH acks, then one request per freed slot.
    rst_n = 1'b0;
    mem[4] = rand_word();
    bus.out_ready = 1'b0;
    fixed_lat = -1;
    steps(2);
    n_ack = 0;
    rst_n = 1'b1;
    steps(40);
    check("t3_acks_full", 64'(n_ack), 64'd4);
    check("t3_req_full", 64'(bus.imem_req), 64'd0);
    check("t3_valid_full", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    steps(20);
    check("t3_acks_one", 64'(n_ack), 64'd5);
    check("t3_req_one", 64'(bus.imem_req), 64'd0);
    bus.out_ready = 1'b1;
    steps(2);
    bus.out_ready = 1'b0;
    steps(20);
    check("t3_acks_two", 64'(n_ack), 64'd7);
    check("t3_req_two", 64'(bus.imem_req), 64'd0);

    // Redirect to 0x40 while fetch of 0x05 is pending; its ack lands 3 cycles later.
    rst_n = 1'b0;
    slow_addr = 5;
    fixed_lat = 1;
    bus.out_ready = 1'b1;
    steps(2);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 10'd5) found = 1;
    end
    check("t4_req5_timeout", 64'(found), 64'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 10'h040;
    bus.out_ready = 1'b0;
    step();
    bus.redirect = 1'b0;
    check("t4_drain_req", 64'(bus.imem_req), 64'd1);
    check("t4_drain_addr", 64'(bus.imem_addr), 64'd5);
    check("t4_flushed", 64'(bus.out_valid), 64'd0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (bus.out_valid) found = 1;
    end
    check("t4_valid_timeout", 64'(found), 64'd1);
    check("t4_npc", 64'(bus.out_npc), 64'h41);
    check("t4_ir", 64'(bus.out_ir), 64'(mem[10'h040]));
    bus.out_ready = 1'b1;
    slow_addr = -1;

    // Halt at address 7, then redirect to 0 resumes.
    rst_n = 1'b0;
    mem[7] = 32'hFC00_0000;
    steps(2);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      step();
      if (bus.halted) found = 1;
    end
    check("t5_halt_timeout", 64'(found), 64'd1);
    steps(2);
    check("t5_last_npc", 64'(last_npc), 64'd8);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.imem_req) cnt++;
    end
    check("t5_no_req", 64'(cnt), 64'd0);
    check("t5_halted", 64'(bus.halted), 64'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 10'd0;
    step();
    bus.redirect = 1'b0;
    check("t5_unhalt", 64'(bus.halted), 64'd0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (bus.imem_req) found = 1;
    end
    check("t5_resume_timeout", 64'(found), 64'd1);
    check("t5_resume_addr", 64'(bus.imem_addr), 64'd0);

    // Wrap: redirect to 0x3FF gives npc 0 and a following fetch at 0.
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 10'h3FF;
    step();
    bus.redirect = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk1);
      if (bus.imem_ack && bus.imem_req && bus.imem_addr == 10'h3FF) found = 1;
    end
    check("t6_ack_timeout", 64'(found), 64'd1);
    check("t6_ack_cycle_valid", 64'(bus.out_valid), 64'(BYP));
    @(negedge clk1);
    check("t6_valid", 64'(bus.out_valid), 64'd1);
    check("t6_npc", 64'(bus.out_npc), 64'd0);
    check("t6_ir", 64'(bus.out_ir), 64'(mem[10'h3FF]));
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 10'd0) found = 1;
    end
    check("t6_next_addr0", 64'(found), 64'd1);
    bus.out_ready = 1'b1;
    steps(20);

    // Randomized traffic with scattered HLTs, redirects and one mid-run reset.
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    for (int i = 0; i < 24; i++) mem[$urandom_range(0, 1023)] = 32'hFC00_0000 | ($urandom() & 32'h03FF_FFFF);
    fixed_lat = -1;
    steps(2);
    rst_n = 1'b1;
    n_xfer = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(1018, 1023));
      if (c == 1500) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    bus.redirect = 1'b0;
    bus.out_ready = 1'b1;
    steps(20);
    n_cmp++;
    assert (n_xfer > 100) else begin
      n_fail++;
      $error("FAIL rand_activity: observed=%0d transfers expected more than 100", n_xfer);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
